// File: rtl/project2_nios2_dct_packer.sv
// Packs 2-bit DCT trace symbols into 30-bit words for the OCI test-bench trace sink.
// Also drives the test_ending / test_has_ended handshake with that sink.
module project2_nios2_dct_packer #(
    parameter int SYM_W = 2,
    parameter int DEPTH = 15,
    parameter int BUF_W = 30,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym_data,
    output logic             sym_ready,
    input  logic             flush,
    input  logic             end_req,
    output logic [BUF_W-1:0] dct_buffer,
    output logic [CNT_W-1:0] dct_count,
    output logic             dct_valid,
    input  logic             out_ready,
    output logic             test_ending,
    output logic             test_has_ended
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [BUF_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic             ending_q, ending_d;
    logic             ended_q, ended_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vld_q, vld_d;

    logic accept, slot_free, transfer;

    // Stale symbols above the fill level never reach the sink.
    function automatic logic [BUF_W-1:0] mask_acc(input logic [BUF_W-1:0] a,
                                                  input logic [CNT_W-1:0] n);
        logic [BUF_W-1:0] m;
        m = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(n)) m[SYM_W*k +: SYM_W] = a[SYM_W*k +: SYM_W];
        end
        return m;
    endfunction

    assign sym_ready = !reset && (acc_cnt_q < FULL) && !flush_pend_q && !ending_q;
    assign accept    = sym_valid && sym_ready;
    assign slot_free = !vld_q || out_ready;
    assign transfer  = slot_free && ((acc_cnt_q == FULL) || (flush_pend_q && acc_cnt_q != '0));

    always_comb begin
        acc_d        = acc_q;
        acc_cnt_d    = acc_cnt_q;
        flush_pend_d = flush_pend_q;
        ending_d     = ending_q;
        ended_d      = ended_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        vld_d        = vld_q;

        if (accept) begin
            acc_d[SYM_W*int'(acc_cnt_q) +: SYM_W] = sym_data;
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end

        if (transfer) begin
            buf_d     = mask_acc(acc_q, acc_cnt_q);
            cnt_d     = acc_cnt_q;
            vld_d     = 1'b1;
            acc_cnt_d = '0;
        end else if (vld_q && out_ready) begin
            vld_d = 1'b0;
        end

        // An empty flush has nothing to emit and simply retires.
        if (flush_pend_q && (transfer || acc_cnt_q == '0)) flush_pend_d = 1'b0;

        if (!ending_q && !flush_pend_q && (flush || end_req)) flush_pend_d = 1'b1;
        if (!ending_q && end_req) ending_d = 1'b1;

        if (ending_q && acc_cnt_q == '0 && !flush_pend_q && slot_free) ended_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            ending_q     <= 1'b0;
            ended_q      <= 1'b0;
            buf_q        <= '0;
            cnt_q        <= '0;
            vld_q        <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
            ending_q     <= ending_d;
            ended_q      <= ended_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            vld_q        <= vld_d;
        end
    end

    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign dct_valid      = vld_q;
    assign test_ending    = ending_q;
    assign test_has_ended = ended_q;

endmodule

// File: tb/tb_project2_nios2_dct_packer.sv
// Scoreboard bench for the DCT packer: directed stimulus pushes expected words, a monitor pops them.
module tb_project2_nios2_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sym_valid;
    logic [1:0]  sym_data;
    logic        sym_ready;
    logic        flush;
    logic        end_req;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        out_ready;
    logic        test_ending;
    logic        test_has_ended;

    always #5 clk = ~clk;

    project2_nios2_dct_packer dut (
        .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_data(sym_data),
        .sym_ready(sym_ready), .flush(flush), .end_req(end_req),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_valid(dct_valid),
        .out_ready(out_ready), .test_ending(test_ending), .test_has_ended(test_has_ended)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [33:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops on every handshake, and checks held words stay put.
    logic        held_v = 1'b0;
    logic [33:0] held_w = '0;
    always @(negedge clk) begin
        logic [33:0] w;
        if (!reset) begin
            if (held_v) check("hold", {31'd0, dct_valid, dct_count, dct_buffer}, {31'd0, 1'b1, held_w});
            if (dct_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h, expected none", {dct_count, dct_buffer});
                end else begin
                    w = exp_q.pop_front();
                    check("word", {30'd0, dct_count, dct_buffer}, {30'd0, w});
                end
            end
            held_v <= dct_valid && !out_ready;
            held_w <= {dct_count, dct_buffer};
        end else begin
            held_v <= 1'b0;
        end
    end

    task automatic send(input logic [1:0] d, input logic fl);
        int waited;
        waited = 0;
        sym_valid = 1'b1;
        sym_data  = d;
        @(negedge clk);
        while (!sym_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!sym_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got sym_ready=0, expected 1 within 200 cycles");
        end
        flush = fl;
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected finish before 300000");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; sym_valid = 1'b0; sym_data = '0; flush = 1'b0;
        end_req = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sym_ready", sym_ready, 0);
        check("rst_dct_valid", dct_valid, 0);
        check("rst_dct_buffer", dct_buffer, 0);
        check("rst_dct_count", dct_count, 0);
        check("rst_test_ending", test_ending, 0);
        check("rst_test_has_ended", test_has_ended, 0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", sym_ready, 1);

        // Full word: symbols 1,2,3,0,... and latency of one cycle after the 15th.
        @(posedge clk); #1;
        out_ready = 1'b1;
        exp_q.push_back({4'd15, 30'h3939_3939});
        for (int k = 0; k < 15; k++) send(2'((k + 1) % 4), 1'b0);
        @(negedge clk);
        check("latency_pre", dct_valid, 0);
        @(negedge clk);
        check("latency_word", dct_valid, 1);
        cycles(3);
        check("q_empty_full", exp_q.size(), 0);

        // Backpressure: 30 symbols against a stalled sink.
        out_ready = 1'b0;
        exp_q.push_back({4'd15, 30'h3939_3939});
        exp_q.push_back({4'd15, 30'h24E4_E4E4});
        for (int k = 0; k < 30; k++) send(2'((k + 1) % 4), 1'b0);
        @(negedge clk);
        check("full_stall_ready", sym_ready, 0);
        check("full_stall_valid", dct_valid, 1);
        cycles(6);
        @(negedge clk);
        check("full_stall_ready_late", sym_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        cycles(5);
        check("q_empty_bp", exp_q.size(), 0);

        // Partial flush with the flush pulse on the third symbol.
        exp_q.push_back({4'd3, 30'h0000_0036});
        send(2'd2, 1'b0);
        send(2'd1, 1'b0);
        send(2'd3, 1'b1);
        cycles(4);
        check("q_empty_partial", exp_q.size(), 0);

        // Empty flush.
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("empty_flush_pend", sym_ready, 0);
        check("empty_flush_novalid", dct_valid, 0);
        @(negedge clk);
        check("empty_flush_clear", sym_ready, 1);
        check("empty_flush_novalid2", dct_valid, 0);
        cycles(2);

        // End sequence.
        out_ready = 1'b0;
        exp_q.push_back({4'd5, 30'h0000_0363});
        send(2'd3, 1'b0);
        send(2'd0, 1'b0);
        send(2'd2, 1'b0);
        send(2'd1, 1'b0);
        send(2'd3, 1'b0);
        end_req = 1'b1;
        @(posedge clk); #1;
        end_req = 1'b0;
        @(negedge clk);
        check("end_ending", test_ending, 1);
        check("end_no_accept", sym_ready, 0);
        cycles(2);
        @(negedge clk);
        check("end_word_held", dct_valid, 1);
        check("end_not_ended", test_has_ended, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("end_not_ended_pre", test_has_ended, 0);
        @(negedge clk);
        check("end_has_ended", test_has_ended, 1);
        check("end_valid_drop", dct_valid, 0);
        @(posedge clk); #1;
        flush = 1'b1; end_req = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; end_req = 1'b0;
        cycles(3);
        @(negedge clk);
        check("end_sticky", {test_ending, test_has_ended, sym_ready, dct_valid}, 4'b1100);
        check("q_empty_end", exp_q.size(), 0);

        // Mid-word reset discards the partial word.
        @(posedge clk); #1;
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        for (int k = 0; k < 7; k++) send(2'(k % 4), 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_outputs", {sym_ready, dct_valid, dct_count, dct_buffer, test_ending, test_has_ended}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.push_back({4'd15, 30'h3939_3939});
        for (int k = 0; k < 15; k++) send(2'((k + 1) % 4), 1'b0);
        cycles(4);
        check("q_empty_midrst", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
